// File: rtl/mtr_drv.sv
// rtl/mtr_drv.sv - dual H-bridge PWM back end with dead time and over-current blanking
//
// Turns the balance controller's 11-bit speed/direction commands into
// period-synchronous PWM gate drives for the left and right wheel bridges.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   pwr_up                         drive enable, sampled at the period boundary
//   lft_spd/lft_rev                left duty command and direction (1 = reverse)
//   rght_spd/rght_rev              right duty command and direction
//   ovr_i_lft/ovr_i_rght           per-side over-current flags, active-high
//   PWM_fwd_*/PWM_rev_*            registered gate drives per side
//   prd_strt                       one-clock pulse during the cycle cnt == 0
module mtr_drv #(
  parameter int DEAD_TIME = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwr_up,
  input  logic [10:0] lft_spd,
  input  logic        lft_rev,
  input  logic [10:0] rght_spd,
  input  logic        rght_rev,
  input  logic        ovr_i_lft,
  input  logic        ovr_i_rght,
  output logic        PWM_fwd_lft,
  output logic        PWM_rev_lft,
  output logic        PWM_fwd_rght,
  output logic        PWM_rev_rght,
  output logic        prd_strt
);

  typedef enum logic [1:0] {
    DRV  = 2'd0,
    DEAD = 2'd1,
    FLT  = 2'd2
  } state_e;

  localparam logic [10:0] DEAD_LOAD = 11'(DEAD_TIME - 1);

  // Index 0 is the left side, index 1 the right side.
  logic [1:0][10:0] spd_in;
  logic [1:0]       rev_in;
  logic [1:0]       ovr_in;

  assign spd_in = {rght_spd, lft_spd};
  assign rev_in = {rght_rev, lft_rev};
  assign ovr_in = {ovr_i_rght, ovr_i_lft};

  logic [10:0]      cnt_q, cnt_d;
  logic             prd_strt_q, prd_strt_d;
  logic             bnd;
  state_e [1:0]     state_q, state_d;
  logic [1:0][10:0] spd_sh_q, spd_sh_d;
  logic [1:0]       rev_sh_q, rev_sh_d;
  logic [1:0][10:0] dead_q, dead_d;
  logic [1:0]       fwd_q, fwd_d;
  logic [1:0]       rev_q, rev_d;
  logic [1:0]       flip;
  logic [1:0]       raw;

  always_comb begin
    cnt_d      = cnt_q + 11'd1;
    bnd        = (cnt_q == 11'd2047);
    // Registered so the pulse lands in the cnt == 0 cycle and stays low in reset.
    prd_strt_d = bnd;
    state_d    = state_q;
    spd_sh_d   = spd_sh_q;
    rev_sh_d   = rev_sh_q;
    dead_d     = dead_q;
    fwd_d      = '0;
    rev_d      = '0;
    flip       = '0;
    raw        = '0;

    for (int i = 0; i < 2; i++) begin
      if (bnd) begin
        // Powered down: duty goes to zero but the direction is held, so a
        // later power-up in the same direction does not trigger dead time.
        spd_sh_d[i] = pwr_up ? spd_in[i] : 11'd0;
        if (pwr_up) begin
          rev_sh_d[i] = rev_in[i];
        end
      end
      flip[i] = bnd & (rev_sh_d[i] != rev_sh_q[i]);

      case (state_q[i])
        DRV: begin
          if (ovr_in[i]) begin
            state_d[i] = FLT;
          end else if (flip[i]) begin
            state_d[i] = DEAD;
            dead_d[i]  = DEAD_LOAD;
          end
        end
        DEAD: begin
          if (ovr_in[i]) begin
            state_d[i] = FLT;
          end else if (dead_q[i] == 11'd0) begin
            state_d[i] = DRV;
          end else begin
            dead_d[i] = dead_q[i] - 11'd1;
          end
        end
        FLT: begin
          if (bnd && !ovr_in[i]) begin
            if (flip[i]) begin
              state_d[i] = DEAD;
              dead_d[i]  = DEAD_LOAD;
            end else begin
              state_d[i] = DRV;
            end
          end
        end
        default: state_d[i] = DRV;
      endcase

      // raw is always low at cnt == 2047, so the gate is low in every cnt == 0
      // cycle and a direction change never sees the old gate across the boundary.
      raw[i] = (cnt_q < spd_sh_q[i]);
      // ovr_in masks the gate directly so blanking takes effect on the next clock.
      fwd_d[i] = (state_q[i] == DRV) & ~ovr_in[i] & raw[i] & ~rev_sh_q[i];
      rev_d[i] = (state_q[i] == DRV) & ~ovr_in[i] & raw[i] &  rev_sh_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      prd_strt_q <= 1'b0;
      spd_sh_q   <= '0;
      rev_sh_q   <= '0;
      dead_q     <= '0;
      fwd_q      <= '0;
      rev_q      <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= DRV;
      end
    end else begin
      cnt_q      <= cnt_d;
      prd_strt_q <= prd_strt_d;
      spd_sh_q   <= spd_sh_d;
      rev_sh_q   <= rev_sh_d;
      dead_q     <= dead_d;
      fwd_q      <= fwd_d;
      rev_q      <= rev_d;
      state_q    <= state_d;
    end
  end

  assign PWM_fwd_lft  = fwd_q[0];
  assign PWM_rev_lft  = rev_q[0];
  assign PWM_fwd_rght = fwd_q[1];
  assign PWM_rev_rght = rev_q[1];
  assign prd_strt     = prd_strt_q;

endmodule

// File: tb/tb_mtr_drv.sv
// tb/tb_mtr_drv.sv - scoreboard bench for mtr_drv, per-period gate pulse counts
module tb_mtr_drv;

  localparam int DT    = 32;
  localparam int NSTEP = 14;
  localparam int OVR_P = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwr_up = 1'b0;
  logic [10:0] lft_spd = '0;
  logic        lft_rev = 1'b0;
  logic [10:0] rght_spd = '0;
  logic        rght_rev = 1'b0;
  logic        ovr_i_lft = 1'b0;
  logic        ovr_i_rght = 1'b0;
  logic        PWM_fwd_lft, PWM_rev_lft, PWM_fwd_rght, PWM_rev_rght, prd_strt;

  mtr_drv #(.DEAD_TIME(DT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwr_up       (pwr_up),
    .lft_spd      (lft_spd),
    .lft_rev      (lft_rev),
    .rght_spd     (rght_spd),
    .rght_rev     (rght_rev),
    .ovr_i_lft    (ovr_i_lft),
    .ovr_i_rght   (ovr_i_rght),
    .PWM_fwd_lft  (PWM_fwd_lft),
    .PWM_rev_lft  (PWM_rev_lft),
    .PWM_fwd_rght (PWM_fwd_rght),
    .PWM_rev_rght (PWM_rev_rght),
    .prd_strt     (prd_strt)
  );

  always #5 clk = ~clk;

  // Per-period expectation: high-clock counts per gate, overlap cycles, prd_strt pulses.
  typedef struct {
    int lf;
    int lr;
    int rf;
    int rr;
    int ov;
    int ps;
  } exp_t;

  // Commands driven mid-period (taking effect next period) and right-side
  // over-current action within the period: 0 none, 1 one-clock pulse at
  // OVR_P, 2 raise at OVR_P and hold, 3 release at cnt 100.
  typedef struct {
    int ls;
    bit lr;
    int rs;
    bit rr;
    bit pw;
    int om;
  } step_t;

  exp_t  sb[$];
  step_t steps [NSTEP];
  int    n_chk = 0;
  int    n_pass = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Clocks a side's active gate is high in a period.
  function automatic int pulse(input int spd, input bit rvs, input bit fc, input int om);
    int st;
    int en;
    if (fc) return 0;
    st = rvs ? DT : 0;
    en = spd;
    if ((om == 1 || om == 2) && en > OVR_P) en = OVR_P;
    return (en > st) ? (en - st) : 0;
  endfunction

  initial begin
    int   m_spd [2];
    bit   m_rev [2];
    bit   m_rvs [2];
    bit   m_fc  [2];
    int   a_lf, a_lr, a_rf, a_rr, a_ov, a_ps;
    int   om;
    bit   nrev;
    exp_t e;
    exp_t g;

    steps[0]  = '{500,  1'b0, 0,    1'b0, 1'b1, 0};
    steps[1]  = '{500,  1'b0, 0,    1'b0, 1'b1, 0};
    steps[2]  = '{500,  1'b0, 2047, 1'b0, 1'b1, 0};
    steps[3]  = '{1000, 1'b0, 2047, 1'b0, 1'b1, 0};
    steps[4]  = '{1000, 1'b1, 1000, 1'b0, 1'b1, 0};
    steps[5]  = '{1000, 1'b1, 1000, 1'b0, 1'b1, 1};
    steps[6]  = '{20,   1'b0, 1000, 1'b0, 1'b1, 2};
    steps[7]  = '{20,   1'b0, 1000, 1'b0, 1'b1, 3};
    steps[8]  = '{1500, 1'b0, 1000, 1'b0, 1'b1, 0};
    steps[9]  = '{1500, 1'b0, 1000, 1'b0, 1'b0, 0};
    steps[10] = '{1500, 1'b0, 1000, 1'b0, 1'b1, 0};
    steps[11] = '{1500, 1'b0, 300,  1'b1, 1'b1, 0};
    steps[12] = '{1500, 1'b0, 300,  1'b1, 1'b1, 0};
    steps[13] = '{1500, 1'b0, 300,  1'b1, 1'b1, 0};

    lft_spd = 11'd500;
    pwr_up  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_fwd_lft",  int'(PWM_fwd_lft),  0);
    check_val("rst_rev_lft",  int'(PWM_rev_lft),  0);
    check_val("rst_fwd_rght", int'(PWM_fwd_rght), 0);
    check_val("rst_rev_rght", int'(PWM_rev_rght), 0);
    check_val("rst_prd_strt", int'(prd_strt),     0);

    for (int s = 0; s < 2; s++) begin
      m_spd[s] = 0;
      m_rev[s] = 1'b0;
      m_rvs[s] = 1'b0;
      m_fc[s]  = 1'b0;
    end

    // Release mid-cycle: the current cycle is cnt == 0 of period 0.
    rst_n = 1'b1;

    for (int k = 0; k < NSTEP; k++) begin
      om   = steps[k].om;
      e.lf = m_rev[0] ? 0 : pulse(m_spd[0], m_rvs[0], m_fc[0], 0);
      e.lr = m_rev[0] ? pulse(m_spd[0], m_rvs[0], m_fc[0], 0) : 0;
      e.rf = m_rev[1] ? 0 : pulse(m_spd[1], m_rvs[1], m_fc[1], om);
      e.rr = m_rev[1] ? pulse(m_spd[1], m_rvs[1], m_fc[1], om) : 0;
      e.ov = 0;
      e.ps = (k == 0) ? 0 : 1;
      sb.push_back(e);

      a_lf = 0; a_lr = 0; a_rf = 0; a_rr = 0; a_ov = 0; a_ps = 0;
      for (int c = 0; c < 2048; c++) begin
        a_lf += int'(PWM_fwd_lft);
        a_lr += int'(PWM_rev_lft);
        a_rf += int'(PWM_fwd_rght);
        a_rr += int'(PWM_rev_rght);
        a_ov += int'(PWM_fwd_lft & PWM_rev_lft) + int'(PWM_fwd_rght & PWM_rev_rght);
        a_ps += int'(prd_strt);

        if (c == 100) begin
          lft_spd  = 11'(steps[k].ls);
          lft_rev  = steps[k].lr;
          rght_spd = 11'(steps[k].rs);
          rght_rev = steps[k].rr;
          pwr_up   = steps[k].pw;
          if (om == 3) ovr_i_rght = 1'b0;
        end
        if (c == OVR_P && (om == 1 || om == 2)) ovr_i_rght = 1'b1;
        if (c == OVR_P + 1 && om == 1) ovr_i_rght = 1'b0;

        if (c == 2047) begin
          if (sb.size() == 0) begin
            check_val($sformatf("p%0d_sb_empty", k), 0, 1);
          end else begin
            g = sb.pop_front();
            check_val($sformatf("p%0d_fwd_lft", k),  a_lf, g.lf);
            check_val($sformatf("p%0d_rev_lft", k),  a_lr, g.lr);
            check_val($sformatf("p%0d_fwd_rght", k), a_rf, g.rf);
            check_val($sformatf("p%0d_rev_rght", k), a_rr, g.rr);
            check_val($sformatf("p%0d_overlap", k),  a_ov, g.ov);
            check_val($sformatf("p%0d_prd_strt", k), a_ps, g.ps);
          end
          // Boundary update of the model from this period's commands.
          nrev     = steps[k].pw ? steps[k].lr : m_rev[0];
          m_rvs[0] = (nrev != m_rev[0]);
          m_rev[0] = nrev;
          m_spd[0] = steps[k].pw ? steps[k].ls : 0;
          m_fc[0]  = 1'b0;
          nrev     = steps[k].pw ? steps[k].rr : m_rev[1];
          m_rvs[1] = (nrev != m_rev[1]);
          m_rev[1] = nrev;
          m_spd[1] = steps[k].pw ? steps[k].rs : 0;
          m_fc[1]  = (om == 2);
        end

        @(posedge clk);
        #1;
      end
    end

    // Now at cnt == 0 of the next period; left runs forward at 1500.
    repeat (50) @(posedge clk);
    #1;
    check_val("pre_arst_fwd_lft", int'(PWM_fwd_lft), 1);
    rst_n = 1'b0;
    #2;
    check_val("arst_fwd_lft",  int'(PWM_fwd_lft),  0);
    check_val("arst_rev_rght", int'(PWM_rev_rght), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
